pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised chain of pipeline registers with per-stage valid bits, stall, flush and automatic bubble insertion. It generalises the fixed Fetch/Decode/Execute/Memory/Writeback register banks into one configurable block of depth `STAGES` and payload `WIDTH`. It is the building block for the stall/flush-capable pipeline driven by the hazard unit. A saturating-free retire counter is included for performance bring-up.

## Interface

**Parameters**
- `WIDTH`, default 32: payload bits per stage.
- `STAGES`, default 4: number of register stages; legal range 1..8.
- `CNT_W`, default 16: retire counter width.

**Ports**
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `in_valid` input, 1: payload at `in_data` is a real instruction.
- `in_data` input, WIDTH: payload entering stage 0.
- `in_ready` output, 1: stage 0 accepts this cycle; equals `!hold[0]`.
- `stall` input, STAGES: bit i requests stage i to hold.
- `flush` input, STAGES: bit i kills the contents of stage i.
- `stage_valid` output, STAGES: valid bit of each stage register.
- `stage_data` output, STAGES*WIDTH: packed stage registers; stage i occupies bits `[i*WIDTH +: WIDTH]`.
- `out_valid` output, 1: equals `stage_valid[STAGES-1]`.
- `out_data` output, WIDTH: equals stage `STAGES-1` data.
- `retire_count` output, CNT_W: number of valid items that have left the last stage.

## Operation

- **Effective hold:** `hold[STAGES-1] = stall[STAGES-1]`; for i < STAGES-1, `hold[i] = stall[i] | hold[i+1]`. A stall freezes its own stage and every upstream stage. This logic is combinational.
- **Per-stage update priority:** reset > flush > hold > bubble > load.
  - `reset`: valid=0, data=0.
  - `flush[i]`: valid=0, data=0. Flush wins over stall on the same stage.
  - `hold[i]`: valid and data keep their values.
  - Bubble: if `!hold[i]`, i>0, and `hold[i-1]`, stage i loads valid=0, data=0. This prevents a held upstream item from being duplicated.
  - Load: stage 0 takes `in_valid`/`in_data`; stage i takes stage i-1's valid and data.
- **Flush within the chain:** flushing stage i does not affect what stage i+1 loads on the same edge. Stage i+1 captures the pre-edge contents of stage i, which is the required Harris-style semantics.
- **Input with `in_ready`=0:** `in_valid`/`in_data` are ignored and not buffered. The upstream source must re-present them.
- **Retire:** an item retires when `out_valid=1` and `!hold[STAGES-1]` at the edge. A flush of the last stage on that edge still counts the item as retired.
  - `retire_count` increments by 1 per retire.
  - It wraps modulo 2^CNT_W and is cleared by `reset`.
- **Invalid payloads:** data of invalid stages are driven 0, never stale.

## Timing

- **Reset:** on the first edge with `reset=1`, all of the following become 0: every `stage_valid`, every `stage_data`, `out_valid`, `out_data` and `retire_count`. `in_ready` = `!hold[0]` (combinational; 1 when `stall`=0).
- **Latency:** an item accepted at edge k appears on `out_data` after edge k+STAGES-1 (visible in the cycle following it). This assumes no holds.
- **Throughput:** one item per cycle when `stall`=0.
- **Combinational paths:** `in_ready` depends combinationally on `stall`. All other outputs are registered.
- **Reset mid-operation:** all in-flight items are dropped, no retire is counted, and there is no partial state.
- **Simultaneous `stall[i]` and `flush[i]`:** stage i is cleared. Upstream stages still hold, because hold is computed from `stall` only. The stage i+1 bubble rule still applies.
- **STAGES=1:** no bubble rule applies. `hold[0]` = `stall[0]`.

## Test plan

- **Streaming:** STAGES=4, `reset` for 2 cycles, then `in_data` = 0x10, 0x11, 0x12… with `in_valid`=1 and no stall.
  - `out_data`=0x10 after the 4th edge, then the sequence continues one value per cycle.
  - After 10 outputs, `retire_count`=10.
- **Stall with bubble:** pipeline full with stages 0..3 = A3,A2,A1,A0 (stage 3 = A0). Assert `stall[1]` for 2 cycles.
  - Stages 0–1 hold A3,A2.
  - Stage 2 receives valid=0 bubbles.
  - Stage 3 gets A1, then a bubble.
  - `in_ready`=0 during the stall.
  - No payload is duplicated or lost.
- **Flush:** stages 0..3 = B3,B2,B1,B0. Pulse `flush[1]` and `flush[0]` for one cycle with `in_valid`=1, `in_data`=0xC0.
  - After the edge: stage0=0,valid0; stage1=0,valid0; stage2=B2; stage3=B1.
  - The 0xC0 offered that cycle is lost (stage 0 flushed).
- **Flush over stall:** `stall[2]` and `flush[2]` set together.
  - Stage 2 becomes invalid/0.
  - Stages 0–1 hold.
  - Stage 3 receives a bubble.
- **Counter wrap and reset:** with CNT_W=4, retire 17 items → `retire_count`=1.
  - Then assert `reset` mid-stream: every output is 0 after one edge, and no further increment occurs that edge.
- **Last-stage stall:** `stall[3]`=1 with `out_valid`=1 for 3 cycles.
  - `out_data` is stable.
  - `retire_count` is unchanged.
  - On release, the count increments by exactly 1.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - configurable pipeline register chain with stall, flush and bubble insertion
module pipe_stage_chain #(
    parameter int WIDTH  = 32,  // payload bits per stage
    parameter int STAGES = 4,   // register stages, 1..8
    parameter int CNT_W  = 16   // retire counter width
) (
    input  logic                     clk,          // single rising-edge clock
    input  logic                     reset,        // synchronous, active-high
    input  logic                     in_valid,     // in_data carries a real item
    input  logic [WIDTH-1:0]         in_data,      // payload entering stage 0
    output logic                     in_ready,     // stage 0 accepts this cycle
    input  logic [STAGES-1:0]        stall,        // per-stage hold request
    input  logic [STAGES-1:0]        flush,        // per-stage kill
    output logic [STAGES-1:0]        stage_valid,  // valid bit of every stage
    output logic [STAGES*WIDTH-1:0]  stage_data,   // stage i at [i*WIDTH +: WIDTH]
    output logic                     out_valid,    // last stage valid
    output logic [WIDTH-1:0]         out_data,     // last stage payload
    output logic [CNT_W-1:0]         retire_count  // items that left the last stage
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_hold;
    logic [WIDTH-1:0]  up_data [STAGES];

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [CNT_W-1:0]  count_q;
    logic              retire;

    // A stall freezes its own stage and everything upstream of it.
    always_comb begin
        hold = stall;
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    // What each stage would load, and whether its source is frozen.
    // The input payload is zeroed when not valid so invalid stages never
    // carry stale data.
    always_comb begin
        up_valid = '0;
        up_hold  = '0;
        for (int i = 0; i < STAGES; i++) begin
            up_data[i] = '0;
        end
        up_valid[0] = in_valid;
        up_data[0]  = in_valid ? in_data : '0;
        for (int i = 1; i < STAGES; i++) begin
            up_valid[i] = valid_q[i-1];
            up_data[i]  = data_q[i-1];
            up_hold[i]  = hold[i-1];
        end
    end

    // Retire is judged on the pre-edge contents, so a flush of the last
    // stage on the same edge still counts the leaving item.
    assign retire = valid_q[STAGES-1] & ~hold[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush[i]) begin
                    valid_q[i] <= 1'b0;
                    data_q[i]  <= '0;
                end else if (!hold[i]) begin
                    if (up_hold[i]) begin
                        // Source is frozen: insert a bubble instead of
                        // duplicating the held item.
                        valid_q[i] <= 1'b0;
                        data_q[i]  <= '0;
                    end else begin
                        valid_q[i] <= up_valid[i];
                        data_q[i]  <= up_data[i];
                    end
                end
            end
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_pack
            assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
        end
    endgenerate

    assign stage_valid  = valid_q;
    assign out_valid    = valid_q[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign retire_count = count_q;
    assign in_ready     = ~hold[0];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed vector bench for pipe_stage_chain
module tb_pipe_stage_chain;

    localparam int WIDTH  = 8;
    localparam int STAGES = 4;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    reset;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_ready;
    logic [STAGES-1:0]       stall;
    logic [STAGES-1:0]       flush;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [CNT_W-1:0]        retire_count;

    int checks;
    int errors;

    pipe_stage_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [7:0]  d;
        logic [3:0]  st;
        logic [3:0]  fl;
        logic        rdy;   // expected in_ready before the edge
        logic [3:0]  v;     // expected stage_valid after the edge
        logic [31:0] sd;    // expected stage_data {s3,s2,s1,s0}
        logic [3:0]  cnt;   // expected retire_count after the edge
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic rst, logic iv, logic [7:0] d, logic [3:0] st,
                                logic [3:0] fl, logic rdy, logic [3:0] v,
                                logic [31:0] sd, logic [3:0] cnt);
        vec_t r;
        r.rst = rst; r.iv = iv; r.d = d; r.st = st; r.fl = fl;
        r.rdy = rdy; r.v = v; r.sd = sd; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [7:0] d,
                         input logic [3:0] st, input logic [3:0] fl);
        reset = rst; in_valid = iv; in_data = d; stall = st; flush = fl;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 8'h00, 4'h0, 4'h0);

        //             rst  iv   d      st     fl     rdy  v      {s3,s2,s1,s0}  cnt
        tbl[0]  = mk(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 4'b0000, 32'h00000000, 4'd0);
        tbl[1]  = mk(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 4'b0000, 32'h00000000, 4'd0);
        tbl[2]  = mk(1'b0, 1'b1, 8'hA0, 4'h0, 4'h0, 1'b1, 4'b0001, 32'h000000A0, 4'd0);
        tbl[3]  = mk(1'b0, 1'b1, 8'hA1, 4'h0, 4'h0, 1'b1, 4'b0011, 32'h0000A0A1, 4'd0);
        tbl[4]  = mk(1'b0, 1'b1, 8'hA2, 4'h0, 4'h0, 1'b1, 4'b0111, 32'h00A0A1A2, 4'd0);
        tbl[5]  = mk(1'b0, 1'b1, 8'hA3, 4'h0, 4'h0, 1'b1, 4'b1111, 32'hA0A1A2A3, 4'd0);
        // stall[1] two cycles: stages 0-1 hold, stage 2 bubbles, A1 then bubble out
        tbl[6]  = mk(1'b0, 1'b1, 8'hA4, 4'h2, 4'h0, 1'b0, 4'b1011, 32'hA100A2A3, 4'd1);
        tbl[7]  = mk(1'b0, 1'b1, 8'hA4, 4'h2, 4'h0, 1'b0, 4'b0011, 32'h0000A2A3, 4'd2);
        tbl[8]  = mk(1'b0, 1'b1, 8'hA4, 4'h0, 4'h0, 1'b1, 4'b0111, 32'h00A2A3A4, 4'd2);
        tbl[9]  = mk(1'b0, 1'b1, 8'hA5, 4'h0, 4'h0, 1'b1, 4'b1111, 32'hA2A3A4A5, 4'd2);
        // flush[1:0] with 0xC0 offered: C0 lost, stage 2/3 take pre-edge values
        tbl[10] = mk(1'b0, 1'b1, 8'hC0, 4'h0, 4'h3, 1'b1, 4'b1100, 32'hA3A40000, 4'd3);
        tbl[11] = mk(1'b0, 1'b1, 8'hA6, 4'h0, 4'h0, 1'b1, 4'b1001, 32'hA40000A6, 4'd4);
        tbl[12] = mk(1'b0, 1'b1, 8'hA7, 4'h0, 4'h0, 1'b1, 4'b0011, 32'h0000A6A7, 4'd5);
        tbl[13] = mk(1'b0, 1'b1, 8'hA8, 4'h0, 4'h0, 1'b1, 4'b0111, 32'h00A6A7A8, 4'd5);
        tbl[14] = mk(1'b0, 1'b1, 8'hA9, 4'h0, 4'h0, 1'b1, 4'b1111, 32'hA6A7A8A9, 4'd5);
        // stall[2]+flush[2]: stage 2 cleared, 0-1 hold, stage 3 bubble
        tbl[15] = mk(1'b0, 1'b1, 8'hAA, 4'h4, 4'h4, 1'b0, 4'b0011, 32'h0000A8A9, 4'd6);
        // invalid input must load zero data, not the junk on in_data
        tbl[16] = mk(1'b0, 1'b0, 8'h55, 4'h0, 4'h0, 1'b1, 4'b0110, 32'h00A8A900, 4'd6);

        tick();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].st, tbl[i].fl);
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
            tick();
            check($sformatf("vec%0d_valid", i), 64'(stage_valid), 64'(tbl[i].v));
            check($sformatf("vec%0d_data", i), 64'(stage_data), 64'(tbl[i].sd));
            check($sformatf("vec%0d_count", i), 64'(retire_count), 64'(tbl[i].cnt));
        end

        // Streaming: two reset cycles, then 0x10, 0x11, ... every cycle
        drive(1'b1, 1'b0, 8'h00, 4'h0, 4'h0);
        tick();
        tick();
        check("stream_reset_count", 64'(retire_count), 64'd0);
        for (int e = 1; e <= 14; e++) begin
            drive(1'b0, 1'b1, 8'(8'h10 + e - 1), 4'h0, 4'h0);
            tick();
            if (e >= 4) begin
                check($sformatf("stream_e%0d_out_valid", e), 64'(out_valid), 64'd1);
                check($sformatf("stream_e%0d_out_data", e), 64'(out_data), 64'(8'h10 + e - 4));
            end
            check($sformatf("stream_e%0d_count", e), 64'(retire_count),
                  64'((e > 4) ? e - 4 : 0));
        end
        check("stream_ten_retired", 64'(retire_count), 64'd10);

        // Last-stage stall for 3 cycles: output frozen, no retire, in_ready low
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 8'h77, 4'h8, 4'h0);
            #1;
            check($sformatf("last_stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            tick();
            check($sformatf("last_stall%0d_out_data", c), 64'(out_data), 64'h1A);
            check($sformatf("last_stall%0d_out_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("last_stall%0d_count", c), 64'(retire_count), 64'd10);
        end
        drive(1'b0, 1'b1, 8'h1E, 4'h0, 4'h0);
        tick();
        check("last_release_count", 64'(retire_count), 64'd11);
        check("last_release_out_data", 64'(out_data), 64'h1B);

        // Counter wrap: 17 retires from a cleared 4-bit counter reads 1
        drive(1'b1, 1'b0, 8'h00, 4'h0, 4'h0);
        tick();
        for (int e = 1; e <= 21; e++) begin
            drive(1'b0, 1'b1, 8'(8'h40 + e), 4'h0, 4'h0);
            tick();
        end
        check("wrap_count", 64'(retire_count), 64'd1);
        check("wrap_full_valid", 64'(stage_valid), 64'hF);

        // Reset mid-stream with a retiring item: everything zero, no increment
        drive(1'b1, 1'b1, 8'h99, 4'h0, 4'h0);
        tick();
        check("midreset_valid", 64'(stage_valid), 64'd0);
        check("midreset_data", 64'(stage_data), 64'd0);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out_data", 64'(out_data), 64'd0);
        check("midreset_count", 64'(retire_count), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
